ext_mem_arbiter: RTL and testbench

Two-master arbiter that shares the single external data memory port (req/we/be/addr/wd/rd/ready protocol) between master 0 (core LSU) and master 1 (DMA / debug / peripheral master).
- Sits between the LSU memory-side outputs and the ext_mem instance inside the unit top level.
- Uses round-robin arbitration with a grant held for a whole transaction until memory signals ready.
- The FSM is registered, so every transaction is preceded by one idle arbitration cycle.

---
 rtl/ext_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_ext_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_mem_arbiter.sv
// Round-robin arbiter sharing one external memory port between two masters.
// Optional bus-hang timeout is built when ARB_TIMEOUT_EN is defined.
module ext_mem_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [DATA_W/8-1:0] m0_be_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wd_i,
    output logic [DATA_W-1:0]   m0_rd_o,
    output logic                m0_ready_o,
    output logic                m0_err_o,
    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [DATA_W/8-1:0] m1_be_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wd_i,
    output logic [DATA_W-1:0]   m1_rd_o,
    output logic                m1_ready_o,
    output logic                m1_err_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wd_o,
    input  logic [DATA_W-1:0]   mem_rd_i,
    input  logic                mem_ready_i
);
    localparam int unsigned BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_e;

    state_e state_q;
    logic   last_grant_q;
    logic   busy0_c;
    logic   busy1_c;
    logic   busy_c;
    logic   timeout_c;
    logic   done_c;

    assign busy0_c = (state_q == BUSY0);
    assign busy1_c = (state_q == BUSY1);
    assign busy_c  = busy0_c || busy1_c;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W   = (CNT_RAW < 8) ? 8 : CNT_RAW;

    logic [CNT_W-1:0] cnt_q;

    // Counts stalled BUSY cycles; held at zero while idle so every grant starts fresh.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (!busy_c) begin
            cnt_q <= '0;
        end else if (!mem_ready_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign timeout_c = busy_c && !mem_ready_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
    // The timeout length only matters when the feature is built in.
    assign timeout_c = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    assign done_c = busy_c && (mem_ready_i || timeout_c);

    // Arbitration FSM; on a tie the master that was not granted last wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m0_req_i && (!m1_req_i || last_grant_q)) begin
                        state_q      <= BUSY0;
                        last_grant_q <= 1'b0;
                    end else if (m1_req_i) begin
                        state_q      <= BUSY1;
                        last_grant_q <= 1'b1;
                    end
                end
                BUSY0, BUSY1: begin
                    if (done_c) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory side follows the granted master's held inputs directly.
    always_comb begin
        mem_req_o  = busy_c;
        mem_we_o   = 1'b0;
        mem_be_o   = BE_W'(0);
        mem_addr_o = ADDR_W'(0);
        mem_wd_o   = DATA_W'(0);
        if (busy0_c) begin
            mem_we_o   = m0_we_i;
            mem_be_o   = m0_be_i;
            mem_addr_o = m0_addr_i;
            mem_wd_o   = m0_wd_i;
        end else if (busy1_c) begin
            mem_we_o   = m1_we_i;
            mem_be_o   = m1_be_i;
            mem_addr_o = m1_addr_i;
            mem_wd_o   = m1_wd_i;
        end
    end

    assign m0_ready_o = busy0_c && done_c;
    assign m1_ready_o = busy1_c && done_c;
    assign m0_err_o   = busy0_c && timeout_c;
    assign m1_err_o   = busy1_c && timeout_c;
    assign m0_rd_o    = (busy0_c && mem_ready_i) ? mem_rd_i : DATA_W'(0);
    assign m1_rd_o    = (busy1_c && mem_ready_i) ? mem_rd_i : DATA_W'(0);

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Bench for ext_mem_arbiter: directed scenarios plus random traffic against
// a transaction-level owner/round-robin model.
module tb_ext_mem_arbiter;
`ifdef ARB_TIMEOUT_EN
    localparam int TO    = 8;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 255;
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req  [2] = '{1'b0, 1'b0};
    logic        we   [2] = '{1'b0, 1'b0};
    logic [3:0]  be   [2] = '{4'h0, 4'h0};
    logic [31:0] addr [2] = '{32'h0, 32'h0};
    logic [31:0] wd   [2] = '{32'h0, 32'h0};
    logic [31:0] rd_o [2];
    logic        rdy_o[2];
    logic        err_o[2];
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wd_o;
    logic [31:0] mem_rd = 32'h0;
    logic        mem_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    // Model: who owns the memory (-1 none), who was granted last, stalled BUSY cycles.
    int own  = -1;
    int last = 1;
    int cnt  = 0;
    bit e_rdy[2] = '{1'b0, 1'b0};

    ext_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_req_i(req[0]), .m0_we_i(we[0]), .m0_be_i(be[0]), .m0_addr_i(addr[0]),
        .m0_wd_i(wd[0]), .m0_rd_o(rd_o[0]), .m0_ready_o(rdy_o[0]), .m0_err_o(err_o[0]),
        .m1_req_i(req[1]), .m1_we_i(we[1]), .m1_be_i(be[1]), .m1_addr_i(addr[1]),
        .m1_wd_i(wd[1]), .m1_rd_o(rd_o[1]), .m1_ready_o(rdy_o[1]), .m1_err_o(err_o[1]),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
        .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own  <= -1;
            last <= 1;
            cnt  <= 0;
        end else if (own < 0) begin
            cnt <= 0;
            if (req[0] && req[1]) begin
                own  <= 1 - last;
                last <= 1 - last;
            end else if (req[0]) begin
                own  <= 0;
                last <= 0;
            end else if (req[1]) begin
                own  <= 1;
                last <= 1;
            end
        end else if (mem_ready || (TO_EN && cnt == TO)) begin
            own <= -1;
        end else begin
            cnt <= cnt + 1;
        end
    end

    // Every-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        int o;
        bit g, to;
        g  = (own >= 0);
        o  = g ? own : 0;
        to = TO_EN && g && !mem_ready && (cnt == TO);
        chk("mem_req", 64'(mem_req_o), 64'(g));
        chk("mem_we", 64'(mem_we_o), g ? 64'(we[o]) : 64'(0));
        chk("mem_be", 64'(mem_be_o), g ? 64'(be[o]) : 64'(0));
        chk("mem_addr", 64'(mem_addr_o), g ? 64'(addr[o]) : 64'(0));
        chk("mem_wd", 64'(mem_wd_o), g ? 64'(wd[o]) : 64'(0));
        for (int m = 0; m < 2; m++) begin
            e_rdy[m] = g && (own == m) && (mem_ready || to);
            chk($sformatf("m%0d_ready", m), 64'(rdy_o[m]), 64'(e_rdy[m]));
            chk($sformatf("m%0d_err", m), 64'(err_o[m]), 64'(g && own == m && to));
            chk($sformatf("m%0d_rd", m), 64'(rd_o[m]),
                (g && own == m && mem_ready) ? 64'(mem_rd) : 64'(0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic new_attrs(input int m);
        we[m]   = 1'($urandom_range(1, 0));
        be[m]   = 4'($urandom);
        addr[m] = $urandom;
        wd[m]   = $urandom;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Zero-wait read by m0; ready asserted already in IDLE must be ignored.
        mem_ready = 1'b1; mem_rd = 32'hCAFEF00D;
        req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'h10; wd[0] = 32'h0;
        @(negedge clk);
        chk("t1_idle_req", 64'(mem_req_o), 64'(0));
        chk("t1_idle_rdy", 64'(rdy_o[0]), 64'(0));
        @(negedge clk);
        chk("t1_busy_req", 64'(mem_req_o), 64'(1));
        chk("t1_addr", 64'(mem_addr_o), 64'h10);
        chk("t1_rdy", 64'(rdy_o[0]), 64'(1));
        chk("t1_rd", 64'(rd_o[0]), 64'hCAFEF00D);
        chk("t1_m1_rdy", 64'(rdy_o[1]), 64'(0));
        chk("t1_m1_rd", 64'(rd_o[1]), 64'(0));
        step();
        req[0] = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("t1_after_req", 64'(mem_req_o), 64'(0));

        // Fresh reset, then both masters hold requests: 0,1,0,1 with a bubble between.
        step();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        req[0] = 1'b1; addr[0] = 32'h100;
        req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 32'h200; wd[1] = 32'h0;
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t2_req", 64'(mem_req_o), 64'(i % 2));
            if (i % 2 == 1)
                chk("t2_addr", 64'(mem_addr_o), (i % 4 == 1) ? 64'h100 : 64'h200);
        end
        step();
        req[0] = 1'b0; req[1] = 1'b0; mem_ready = 1'b0;

        // m1 partial write with a 5-cycle memory stall.
        step();
        req[1] = 1'b1; we[1] = 1'b1; be[1] = 4'b0011; addr[1] = 32'h20; wd[1] = 32'h0000ABCD;
        @(negedge clk);
        chk("t3_idle", 64'(mem_req_o), 64'(0));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_we", 64'(mem_we_o), 64'(1));
            chk("t3_be", 64'(mem_be_o), 64'b0011);
            chk("t3_wd", 64'(mem_wd_o), 64'h0000ABCD);
            chk("t3_wait_rdy", 64'(rdy_o[1]), 64'(0));
        end
        step();
        mem_ready = 1'b1;
        @(negedge clk);
        chk("t3_rdy", 64'(rdy_o[1]), 64'(1));
        step();
        req[1] = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("t3_single_pulse", 64'(rdy_o[1]), 64'(0));

        // Reset in the middle of a BUSY0 transaction.
        step();
        req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'h44;
        @(negedge clk);
        @(negedge clk);
        chk("t4_busy", 64'(mem_req_o), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("t4_async_req", 64'(mem_req_o), 64'(0));
        chk("t4_no_rdy", 64'(rdy_o[0]), 64'(0));
        req[1] = 1'b1; addr[1] = 32'h88; we[1] = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t4_tie_m0", 64'(mem_addr_o), 64'h44);
        step();
        req[1] = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        step();
        req[0] = 1'b0; mem_ready = 1'b0;

`ifdef ARB_TIMEOUT_EN
        // Memory never answers: abort after TO stalled BUSY cycles, then serve normally.
        step();
        req[0] = 1'b1; addr[0] = 32'h55; mem_rd = 32'h12345678;
        @(negedge clk);
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            chk("to_wait", 64'(rdy_o[0]), 64'(0));
        end
        @(negedge clk);
        chk("to_rdy", 64'(rdy_o[0]), 64'(1));
        chk("to_err", 64'(err_o[0]), 64'(1));
        chk("to_rd", 64'(rd_o[0]), 64'(0));
        @(negedge clk);
        step();
        mem_ready = 1'b1;
        @(negedge clk);
        chk("to_next_rdy", 64'(rdy_o[0]), 64'(1));
        chk("to_next_err", 64'(err_o[0]), 64'(0));
        step();
        mem_ready = 1'b0;
        @(negedge clk);
        for (int k = 0; k < TO; k++) @(negedge clk);
        step();
        mem_ready = 1'b1;
        @(negedge clk);
        chk("to_edge_err", 64'(err_o[0]), 64'(0));
        chk("to_edge_rd", 64'(rd_o[0]), 64'h12345678);
        step();
        req[0] = 1'b0; mem_ready = 1'b0;
`endif

        // Random traffic; masters hold until ready, may drop while not granted.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            for (int m = 0; m < 2; m++) begin
                if (req[m] && e_rdy[m]) begin
                    if ($urandom_range(1, 0) == 1) new_attrs(m);
                    else req[m] = 1'b0;
                end else if (!req[m]) begin
                    if ($urandom_range(9, 0) < 4) begin
                        req[m] = 1'b1;
                        new_attrs(m);
                    end
                end else if (own != m && $urandom_range(19, 0) == 0) begin
                    req[m] = 1'b0;
                end
            end
            mem_ready = ($urandom_range(9, 0) < 4);
            mem_rd    = $urandom;
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
